// File: rtl/uart_tx_queue.sv
// -----------------------------------------------------------------------------
// uart_tx_queue
//   Byte FIFO plus launch FSM feeding the transmit side of uart2. Producers push
//   bytes at any rate; the FSM hands them to uart2 one at a time, waiting for
//   tx_busy to rise and fall between launches. If tx_busy never rises, the byte
//   is dropped after BUSY_TIMEOUT cycles and is not retried.
//
// Ports
//   clk       in   system clock
//   reset     in   synchronous, active-low
//   wr_en     in   push wr_data this cycle
//   wr_data   in   byte to queue
//   clr_ovf   in   clear sticky overflow (a simultaneous overflow event wins)
//   tx_busy   in   uart2 transmitter busy
//   tx_start  out  one-cycle launch pulse to uart2
//   tx_data   out  byte to uart2, held from launch until the FSM returns to IDLE
//   full      out  count == DEPTH
//   empty     out  count == 0
//   count     out  occupied entries, 0..DEPTH
//   overflow  out  sticky: a push was dropped because the queue was full
// -----------------------------------------------------------------------------
module uart_tx_queue #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              clr_ovf,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W + 1)'(DEPTH);
  localparam logic [7:0]      TIMEOUT_C = 8'(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                tx_start_q, tx_start_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic [7:0]          timer_q, timer_d;
  logic [7:0]          mem_q [DEPTH];

  logic                pop;
  logic                push;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // The FSM is the only reader, and it pops exactly once per LAUNCH. A full
  // queue still accepts a push in that cycle because a slot is freed.
  assign pop  = (state_q == LAUNCH);
  assign push = wr_en && (!full || pop);

  // FIFO bookkeeping
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase

    // Set has priority over clear so a drop is never lost.
    if (wr_en && !push)  overflow_d = 1'b1;
    else if (clr_ovf)    overflow_d = 1'b0;
  end

  // Launch FSM
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;

    unique case (state_q)
      IDLE: begin
        // A stale tx_busy in IDLE also blocks launch.
        if (!empty && !tx_busy) state_d = LAUNCH;
      end
      LAUNCH: begin
        tx_start_d = 1'b1;
        tx_data_d  = mem_q[rd_ptr_q];
        timer_d    = 8'd0;
        state_d    = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy)                  state_d = WAIT_DONE;
        else if (timer_q == TIMEOUT_C) state_d = IDLE;
        else                          timer_d = timer_q + 8'd1;
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!reset) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      timer_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      timer_q    <= timer_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (reset && push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_queue
//   Directed bench for uart_tx_queue. A small uart2 stand-in raises tx_busy one
//   cycle after each tx_start and holds it for busy_len cycles; force_busy holds
//   tx_busy high externally. A monitor logs every launched byte and its cycle.
// -----------------------------------------------------------------------------
module tb_uart_tx_queue;

  localparam int DEPTH        = 16;
  localparam int ADDR_W       = 4;
  localparam int BUSY_TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              clr_ovf;
  logic              tx_busy;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;

  logic force_busy = 1'b0;
  logic model_en   = 1'b0;
  logic model_busy = 1'b0;
  int   busy_len   = 100;
  int   busy_cnt   = 0;

  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [7:0] sent_q [$];
  int         pulse_cyc [$];

  uart_tx_queue #(
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W),
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .clr_ovf (clr_ovf),
    .tx_busy (tx_busy),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign tx_busy = model_busy | force_busy;

  // uart2 stand-in: busy from the cycle after tx_start for busy_len cycles.
  always @(posedge clk) begin
    if (!reset) begin
      model_busy <= 1'b0;
      busy_cnt   <= 0;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) model_busy <= 1'b0;
    end else if (model_en && tx_start) begin
      model_busy <= 1'b1;
      busy_cnt   <= busy_len;
    end
  end

  // Launch monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (tx_start) begin
      sent_q.push_back(tx_data);
      pulse_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  // Bounded wait for the monitor to log n launches; expiry is a failed check.
  task automatic wait_pulses(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (sent_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(sent_q.size() >= n), 32'd1);
  endtask

  initial begin
    int p_before;
    int gap;

    // 1: reset held 3 clocks with a push requested
    reset   = 1'b0;
    wr_en   = 1'b1;
    wr_data = 8'h99;
    clr_ovf = 1'b0;
    ticks(3);
    check("rst_count",    32'(count),    32'd0);
    check("rst_empty",    32'(empty),    32'd1);
    check("rst_full",     32'(full),     32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_tx_data",  32'(tx_data),  32'h00);
    wr_en = 1'b0;
    reset = 1'b1;
    tick();

    // 2: ordered drain of three bytes
    model_en = 1'b1;
    busy_len = 100;
    sent_q.delete();
    pulse_cyc.delete();
    wr_en = 1'b1;
    wr_data = 8'h41; tick();
    wr_data = 8'h42; tick();
    wr_data = 8'h43; tick();
    wr_en = 1'b0;
    wait_pulses(3, 1000, "drain_wait");
    ticks(150);
    check("drain_pulses", 32'(sent_q.size()), 32'd3);
    if (sent_q.size() >= 3) begin
      check("drain_b0", 32'(sent_q[0]), 32'h41);
      check("drain_b1", 32'(sent_q[1]), 32'h42);
      check("drain_b2", 32'(sent_q[2]), 32'h43);
    end
    check("drain_empty", 32'(empty), 32'd1);

    // 3: overflow with busy held high
    force_busy = 1'b1;
    sent_q.delete();
    pulse_cyc.delete();
    wr_en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wr_data = 8'(i);
      tick();
    end
    wr_en = 1'b0;
    check("ovf_full",     32'(full),     32'd1);
    check("ovf_count",    32'(count),    32'd16);
    check("ovf_overflow", 32'(overflow), 32'd1);
    check("ovf_no_launch", 32'(sent_q.size()), 32'd0);
    force_busy = 1'b0;
    wait_pulses(16, 3000, "ovf_wait");
    ticks(150);
    check("ovf_pulses", 32'(sent_q.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < sent_q.size()) check($sformatf("ovf_b%0d", i), 32'(sent_q[i]), 32'(i));
    end
    check("ovf_empty",  32'(empty),    32'd1);
    check("ovf_sticky", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // 4: full queue, push in the LAUNCH cycle
    force_busy = 1'b1;
    sent_q.delete();
    pulse_cyc.delete();
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = 8'hB0 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    check("fp_full", 32'(full), 32'd1);
    force_busy = 1'b0;
    tick();                       // FSM now in LAUNCH
    wr_en   = 1'b1;
    wr_data = 8'hAA;
    tick();                       // pop and push happened together
    wr_en = 1'b0;
    check("fp_tx_start", 32'(tx_start), 32'd1);
    check("fp_count",    32'(count),    32'd16);
    check("fp_full2",    32'(full),     32'd1);
    check("fp_overflow", 32'(overflow), 32'd0);
    wait_pulses(17, 3000, "fp_wait");
    ticks(150);
    check("fp_pulses", 32'(sent_q.size()), 32'd17);
    if (sent_q.size() >= 17) begin
      check("fp_first", 32'(sent_q[0]),  32'hB0);
      check("fp_b15",   32'(sent_q[15]), 32'hBF);
      check("fp_17th",  32'(sent_q[16]), 32'hAA);
    end
    check("fp_empty", 32'(empty), 32'd1);

    // 5: timeout with tx_busy tied low
    model_en = 1'b0;
    sent_q.delete();
    pulse_cyc.delete();
    push_byte(8'h55);
    wait_pulses(1, 20, "to_wait1");
    push_byte(8'h56);
    wait_pulses(2, 40, "to_wait2");
    ticks(30);
    check("to_pulses", 32'(sent_q.size()), 32'd2);
    if (sent_q.size() >= 2) begin
      check("to_b0", 32'(sent_q[0]), 32'h55);
      check("to_b1", 32'(sent_q[1]), 32'h56);
      // LAUNCH, 9 WAIT_BUSY cycles, IDLE, LAUNCH, then the next pulse.
      gap = pulse_cyc[1] - pulse_cyc[0];
      check("to_gap", 32'(gap), 32'(BUSY_TIMEOUT + 3));
    end

    // 6: reset during WAIT_DONE
    model_en = 1'b1;
    busy_len = 100;
    sent_q.delete();
    pulse_cyc.delete();
    wr_en = 1'b1;
    wr_data = 8'h61; tick();
    wr_data = 8'h62; tick();
    wr_data = 8'h63; tick();
    wr_data = 8'h64; tick();
    wr_en = 1'b0;
    wait_pulses(1, 20, "mr_wait");
    ticks(10);
    check("mr_pre_count", 32'(count),   32'd3);
    check("mr_pre_data",  32'(tx_data), 32'h61);
    reset = 1'b0;
    tick();
    check("mr_count",    32'(count),    32'd0);
    check("mr_empty",    32'(empty),    32'd1);
    check("mr_full",     32'(full),     32'd0);
    check("mr_tx_start", 32'(tx_start), 32'd0);
    check("mr_overflow", 32'(overflow), 32'd0);
    check("mr_tx_data",  32'(tx_data),  32'h00);
    reset = 1'b1;
    p_before = sent_q.size();
    ticks(300);
    check("mr_no_launch", 32'(sent_q.size()), 32'(p_before));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
